// File: rtl/mem_noc_interface_if.sv
// NoC/memory bus bundle for mem_noc_interface.
// slave = network interface side, master = router/memory side.
interface mem_noc_interface_if;
  logic [32:0] pkt_in_data;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [32:0] pkt_out_data;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [1:0]  mem_req_t;
  logic [5:0]  mem_req_x;
  logic [5:0]  mem_req_y;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_data;
  logic        err_drop;

  modport slave (
    input  pkt_in_data, pkt_in_valid,
    output pkt_in_ready,
    output pkt_out_data, pkt_out_valid,
    input  pkt_out_ready,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_write, mem_req_t,
    output mem_req_x, mem_req_y,
    output mem_req_wdata,
    input  mem_rsp_valid,
    output mem_rsp_ready,
    input  mem_rsp_data,
    output err_drop
  );

  modport master (
    output pkt_in_data, pkt_in_valid,
    input  pkt_in_ready,
    input  pkt_out_data, pkt_out_valid,
    output pkt_out_ready,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_write, mem_req_t,
    input  mem_req_x, mem_req_y,
    input  mem_req_wdata,
    output mem_rsp_valid,
    input  mem_rsp_ready,
    output mem_rsp_data,
    input  err_drop
  );
endinterface

// File: rtl/mem_noc_interface.sv
// NoC network interface for the memory block: ingress flit FIFO,
// header decode into memory commands, 2-flit read responses.
module mem_noc_interface #(
  parameter logic [3:0] NODE_ADDR  = 4'd5,
  parameter int         FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  mem_noc_interface_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    HDR,
    WAIT_DATA,
    ISSUE,
    WAIT_RSP,
    SEND_HDR,
    SEND_DATA
  } state_e;

  logic [32:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [32:0]   head;

  state_e        state_q;
  logic          skip_q;
  logic          err_q;
  logic          wr_q;
  logic [1:0]    t_q;
  logic [5:0]    x_q;
  logic [5:0]    y_q;
  logic [3:0]    src_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          req_valid_q;
  logic          rsp_ready_q;
  logic          out_valid_q;
  logic [32:0]   out_data_q;

  logic          is_data;
  logic          is_mine;
  logic          is_foreign;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = bus.pkt_in_valid && !full;
  assign head  = fifo_q[rd_ptr_q];

  assign is_data    = head[32];
  assign is_mine    = !head[32] && (head[31:28] == NODE_ADDR);
  assign is_foreign = !head[32] && (head[31:28] != NODE_ADDR);

  assign bus.pkt_in_ready  = !full;
  assign bus.pkt_out_data  = out_data_q;
  assign bus.pkt_out_valid = out_valid_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_write = wr_q;
  assign bus.mem_req_t     = t_q;
  assign bus.mem_req_x     = x_q;
  assign bus.mem_req_y     = y_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_rsp_ready = rsp_ready_q;
  assign bus.err_drop      = err_q;

  // Head is consumed in HDR always, in WAIT_DATA only for a data flit.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      unique case (state_q)
        HDR:       pop = 1'b1;
        WAIT_DATA: pop = head[32];
        default:   pop = 1'b0;
      endcase
    end
  end

  // Ingress FIFO storage and pointers; no bypass path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.pkt_in_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Packet FSM with registered command/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      skip_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      t_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      src_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        HDR: begin
          if (!empty) begin
            unique case (1'b1)
              is_data: begin
                if (skip_q) skip_q <= 1'b0;
                else        err_q  <= 1'b1;
              end
              is_foreign: begin
                err_q  <= 1'b1;
                skip_q <= head[23];
              end
              is_mine: begin
                skip_q <= 1'b0;
                wr_q   <= head[23];
                src_q  <= head[27:24];
                t_q    <= head[22:21];
                x_q    <= head[20:15];
                y_q    <= head[14:9];
                if (head[23]) begin
                  state_q <= WAIT_DATA;
                end else begin
                  wdata_q     <= '0;
                  req_valid_q <= 1'b1;
                  state_q     <= ISSUE;
                end
              end
              default: state_q <= HDR;
            endcase
          end
        end
        WAIT_DATA: begin
          if (!empty) begin
            if (head[32]) begin
              wdata_q     <= head[31:0];
              req_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              err_q   <= 1'b1;
              state_q <= HDR;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (wr_q) begin
              state_q <= HDR;
            end else begin
              rsp_ready_q <= 1'b1;
              state_q     <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (bus.mem_rsp_valid) begin
            rsp_ready_q <= 1'b0;
            rdata_q     <= bus.mem_rsp_data;
            out_valid_q <= 1'b1;
            out_data_q  <= {1'b0, src_q, NODE_ADDR, 1'b0,
                            t_q, x_q, y_q, 9'd0};
            state_q     <= SEND_HDR;
          end
        end
        SEND_HDR: begin
          if (bus.pkt_out_ready) begin
            out_data_q <= {1'b1, rdata_q};
            state_q    <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (bus.pkt_out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            state_q     <= HDR;
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

endmodule
